// File: rtl/data_deinterconnect_0_if.sv
// Return-path bundle: mode select, three result sources (A, C, D) and the 256-bit output stream.
// The deinterconnect connects through the slave modport; the environment drives it through master.
interface data_deinterconnect_0_if;
    logic          mode;
    logic [1535:0] s_res_a_tdata;
    logic          s_res_a_tvalid;
    logic          s_res_a_tready;
    logic [1535:0] s_res_c_tdata;
    logic          s_res_c_tvalid;
    logic          s_res_c_tready;
    logic [255:0]  s_res_d_tdata;
    logic          s_res_d_tvalid;
    logic          s_res_d_tready;
    logic [255:0]  m_out_tdata;
    logic          m_out_tvalid;
    logic          m_out_tready;
    logic          m_out_tlast;

    modport slave (
        input  mode,
        input  s_res_a_tdata, s_res_a_tvalid,
        output s_res_a_tready,
        input  s_res_c_tdata, s_res_c_tvalid,
        output s_res_c_tready,
        input  s_res_d_tdata, s_res_d_tvalid,
        output s_res_d_tready,
        output m_out_tdata, m_out_tvalid, m_out_tlast,
        input  m_out_tready
    );

    modport master (
        output mode,
        output s_res_a_tdata, s_res_a_tvalid,
        input  s_res_a_tready,
        output s_res_c_tdata, s_res_c_tvalid,
        input  s_res_c_tready,
        output s_res_d_tdata, s_res_d_tvalid,
        input  s_res_d_tready,
        input  m_out_tdata, m_out_tvalid, m_out_tlast,
        output m_out_tready
    );
endinterface

// File: rtl/data_deinterconnect_0.sv
// Serialises 1536-bit A words (6 beats) or C+D joins (7 beats) onto a 256-bit stream with TLAST framing.
// Latency: first beat one cycle after accept; back-to-back words with no bubble.
// Backpressure: m_out_tready stalls beats; sources are readied only when idle or on the final-beat handshake.
// Optional macro DEINT_PERF_CNT_EN adds perf_word_cnt (accepted input words).
module data_deinterconnect_0 #(
    parameter int FRAME_WORDS = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    data_deinterconnect_0_if.slave bus
`ifdef DEINT_PERF_CNT_EN
    ,
    output logic [31:0]            perf_word_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state;
    logic [2:0]     beat_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic           mode_r;
    logic [1535:0]  buf_q;
    logic [255:0]   dbuf_q;
    logic [255:0]   out_dat_q;
    logic           out_vld_q;
    logic           out_last_q;

    logic [2:0]     last_idx;
    logic [2:0]     next_beat;
    logic [255:0]   next_slice;
    logic           last_hs;
    logic           word_wrap;
    logic           next_first;
    logic           acc_mode;
    logic           take_en;
    logic           a_rdy;
    logic           cd_rdy;
    logic           accept;

    assign last_idx  = mode_r ? 3'd6 : 3'd5;
    assign next_beat = beat_cnt + 3'd1;
    assign word_wrap = (word_cnt == LAST_WORD);
    assign last_hs   = (state == SEND) && (beat_cnt == last_idx) && bus.m_out_tready;

    // The word being accepted opens a frame when the counter is at 0 (idle) or is about to wrap (back-to-back).
    assign next_first = (state == SEND) ? word_wrap : (word_cnt == '0);
    assign acc_mode   = next_first ? bus.mode : mode_r;

    assign take_en = ~rst & ((state == IDLE) | last_hs);
    assign a_rdy   = take_en & ~acc_mode;
    assign cd_rdy  = take_en & acc_mode & bus.s_res_c_tvalid & bus.s_res_d_tvalid;
    assign accept  = (a_rdy & bus.s_res_a_tvalid) | cd_rdy;

    assign bus.s_res_a_tready = a_rdy;
    assign bus.s_res_c_tready = cd_rdy;
    assign bus.s_res_d_tready = cd_rdy;
    assign bus.m_out_tdata    = out_dat_q;
    assign bus.m_out_tvalid   = out_vld_q;
    assign bus.m_out_tlast    = out_last_q;

    always_comb begin
        next_slice = dbuf_q;
        case (next_beat)
            3'd1:    next_slice = buf_q[511:256];
            3'd2:    next_slice = buf_q[767:512];
            3'd3:    next_slice = buf_q[1023:768];
            3'd4:    next_slice = buf_q[1279:1024];
            3'd5:    next_slice = buf_q[1535:1280];
            default: next_slice = dbuf_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            word_cnt   <= '0;
            mode_r     <= 1'b0;
            buf_q      <= '0;
            dbuf_q     <= '0;
            out_dat_q  <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            if (last_hs) begin
                word_cnt <= word_wrap ? '0 : word_cnt + 1'b1;
            end
            if (accept) begin
                state      <= SEND;
                beat_cnt   <= '0;
                mode_r     <= acc_mode;
                out_vld_q  <= 1'b1;
                out_last_q <= 1'b0;
                if (acc_mode) begin
                    buf_q     <= bus.s_res_c_tdata;
                    dbuf_q    <= bus.s_res_d_tdata;
                    out_dat_q <= bus.s_res_c_tdata[255:0];
                end else begin
                    buf_q     <= bus.s_res_a_tdata;
                    out_dat_q <= bus.s_res_a_tdata[255:0];
                end
            end else if (last_hs) begin
                state      <= IDLE;
                out_vld_q  <= 1'b0;
                out_last_q <= 1'b0;
            end else if ((state == SEND) && bus.m_out_tready) begin
                beat_cnt   <= next_beat;
                out_dat_q  <= next_slice;
                out_last_q <= (next_beat == last_idx) && word_wrap;
            end
        end
    end

`ifdef DEINT_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_word_cnt = perf_q;
`endif

endmodule
